pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_pkg.sv | 39 +++
 rtl/fwd_match.sv | 13 +
 rtl/pipe_hazard_ctrl.sv | 150 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Covers FSM states, scoreboard slots, forwarding bit indices and counter width.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned STALL_CNT_W = 16;
  localparam int unsigned FWD_EXMEM   = 0;
  localparam int unsigned FWD_MEMWB   = 1;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StLuStall = 2'd1,
    StMcWait  = 2'd2
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       reg_write;
    logic       is_load;
  } slot_t;

  localparam slot_t SLOT_NONE = '0;

  function automatic slot_t make_slot(input logic valid, input logic [4:0] rs1,
                                      input logic [4:0] rs2, input logic [4:0] rd,
                                      input logic reg_write, input logic is_load);
    slot_t s;
    s.valid     = valid;
    s.rs1       = rs1;
    s.rs2       = rs2;
    s.rd        = rd;
    s.reg_write = reg_write;
    s.is_load   = is_load;
    return s;
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Compares one scoreboard slot's destination against one source register.
// x0 is never a forwarding source.
module fwd_match (
  input  logic       i_valid,
  input  logic       i_reg_write,
  input  logic [4:0] i_rd,
  input  logic [4:0] i_rs,
  output logic       o_match
);

  assign o_match = i_valid && i_reg_write && (i_rd != 5'd0) && (i_rd == i_rs);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller: tracks EX/MEM/WB slots, resolves forwarding, load-use,
// branch flush and multicycle-op stalls, and counts fetch-stall cycles.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   id_valid,
  input  logic [4:0]             id_rs1,
  input  logic [4:0]             id_rs2,
  input  logic [4:0]             id_rd,
  input  logic                   id_reg_write,
  input  logic                   id_is_load,
  input  logic                   ex_branch_taken,
  input  logic                   ex_mc_start,
  input  logic                   ex_mc_done,
  output logic                   stall_if,
  output logic                   stall_id,
  output logic                   stall_ex,
  output logic                   flush_id,
  output logic                   bubble_ex,
  output logic [1:0]             f_rs1,
  output logic [1:0]             f_rs2,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic [1:0]             state
);

  state_e                 r_state, w_state_next;
  slot_t                  r_ex, r_mem, r_wb;
  slot_t                  w_id_slot;
  logic                   w_load_use;
  logic                   w_mem_rs1, w_mem_rs2, w_wb_rs1, w_wb_rs2;
  logic [STALL_CNT_W-1:0] r_stall_cnt;
  logic                   w_unused_wb;

  assign w_id_slot = make_slot(id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_is_load);

  fwd_match u_fwd_mem_rs1 (
    .i_valid     (r_mem.valid),
    .i_reg_write (r_mem.reg_write),
    .i_rd        (r_mem.rd),
    .i_rs        (r_ex.rs1),
    .o_match     (w_mem_rs1)
  );

  fwd_match u_fwd_mem_rs2 (
    .i_valid     (r_mem.valid),
    .i_reg_write (r_mem.reg_write),
    .i_rd        (r_mem.rd),
    .i_rs        (r_ex.rs2),
    .o_match     (w_mem_rs2)
  );

  fwd_match u_fwd_wb_rs1 (
    .i_valid     (r_wb.valid),
    .i_reg_write (r_wb.reg_write),
    .i_rd        (r_wb.rd),
    .i_rs        (r_ex.rs1),
    .o_match     (w_wb_rs1)
  );

  fwd_match u_fwd_wb_rs2 (
    .i_valid     (r_wb.valid),
    .i_reg_write (r_wb.reg_write),
    .i_rd        (r_wb.rd),
    .i_rs        (r_ex.rs2),
    .o_match     (w_wb_rs2)
  );

  // EX/MEM wins over MEM/WB, so the two bits are mutually exclusive.
  always_comb begin
    f_rs1            = 2'b00;
    f_rs2            = 2'b00;
    f_rs1[FWD_EXMEM] = w_mem_rs1;
    f_rs1[FWD_MEMWB] = w_wb_rs1 && !w_mem_rs1;
    f_rs2[FWD_EXMEM] = w_mem_rs2;
    f_rs2[FWD_MEMWB] = w_wb_rs2 && !w_mem_rs2;
  end

  assign w_load_use = r_ex.valid && r_ex.is_load && (r_ex.rd != 5'd0) && id_valid &&
                      ((r_ex.rd == id_rs1) || (r_ex.rd == id_rs2));

  always_comb begin
    w_state_next = r_state;
    stall_if     = 1'b0;
    stall_id     = 1'b0;
    stall_ex     = 1'b0;
    flush_id     = 1'b0;
    bubble_ex    = 1'b0;
    unique case (r_state)
      StRun: begin
        if (ex_branch_taken) begin
          flush_id  = 1'b1;
          bubble_ex = 1'b1;
        end else if (ex_mc_start) begin
          w_state_next = StMcWait;
        end else if (w_load_use) begin
          stall_if     = 1'b1;
          stall_id     = 1'b1;
          bubble_ex    = 1'b1;
          w_state_next = StLuStall;
        end
      end
      StLuStall: begin
        w_state_next = StRun;
      end
      StMcWait: begin
        if (ex_mc_done) begin
          w_state_next = StRun;
        end else begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          stall_ex = 1'b1;
        end
      end
      default: begin
        w_state_next = StRun;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StRun;
      r_ex        <= SLOT_NONE;
      r_mem       <= SLOT_NONE;
      r_wb        <= SLOT_NONE;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (stall_ex) begin
        r_wb <= SLOT_NONE;
      end else begin
        r_wb  <= r_mem;
        r_mem <= r_ex;
        r_ex  <= (bubble_ex || !id_valid) ? SLOT_NONE : w_id_slot;
      end
      if (stall_if && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
      end
    end
  end

  // WB only feeds forwarding; its source fields are carried but never read.
  assign w_unused_wb = ^{r_wb.rs1, r_wb.rs2, r_wb.is_load};

  assign stall_cnt = r_stall_cnt;
  assign state     = r_state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scenario-driven bench for pipe_hazard_ctrl: per-cycle stimulus tables with
// expected outputs queued at drive time and compared at the falling edge.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rw;
    logic       ld;
    logic       br;
    logic       mcs;
    logic       mcd;
  } stim_t;

  typedef struct packed {
    logic        sif;
    logic        sid;
    logic        sex;
    logic        fl;
    logic        bub;
    logic [1:0]  f1;
    logic [1:0]  f2;
    logic [1:0]  st;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_reg_write, id_is_load;
  logic        ex_branch_taken, ex_mc_start, ex_mc_done;
  logic        stall_if, stall_id, stall_ex, flush_id, bubble_ex;
  logic [1:0]  f_rs1, f_rs2, state;
  logic [15:0] stall_cnt;

  int   n_run  = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_rd           (id_rd),
    .id_reg_write    (id_reg_write),
    .id_is_load      (id_is_load),
    .ex_branch_taken (ex_branch_taken),
    .ex_mc_start     (ex_mc_start),
    .ex_mc_done      (ex_mc_done),
    .stall_if        (stall_if),
    .stall_id        (stall_id),
    .stall_ex        (stall_ex),
    .flush_id        (flush_id),
    .bubble_ex       (bubble_ex),
    .f_rs1           (f_rs1),
    .f_rs2           (f_rs2),
    .stall_cnt       (stall_cnt),
    .state           (state)
  );

  function automatic stim_t ms(input logic rst, input logic v, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [4:0] rd, input logic rw,
                               input logic ld, input logic br, input logic mcs,
                               input logic mcd);
    return '{rst: rst, v: v, rs1: rs1, rs2: rs2, rd: rd, rw: rw, ld: ld, br: br, mcs: mcs,
             mcd: mcd};
  endfunction

  function automatic exp_t me(input logic sif, input logic sid, input logic sex, input logic fl,
                              input logic bub, input logic [1:0] f1, input logic [1:0] f2,
                              input logic [1:0] st, input logic [15:0] cnt);
    return '{sif: sif, sid: sid, sex: sex, fl: fl, bub: bub, f1: f1, f2: f2, st: st, cnt: cnt};
  endfunction

  function automatic exp_t sample();
    return exp_t'({stall_if, stall_id, stall_ex, flush_id, bubble_ex, f_rs1, f_rs2, state,
                   stall_cnt});
  endfunction

  task automatic apply(input stim_t s);
    reset           = s.rst;
    id_valid        = s.v;
    id_rs1          = s.rs1;
    id_rs2          = s.rs2;
    id_rd           = s.rd;
    id_reg_write    = s.rw;
    id_is_load      = s.ld;
    ex_branch_taken = s.br;
    ex_mc_start     = s.mcs;
    ex_mc_done      = s.mcd;
  endtask

  task automatic do_reset();
    apply(ms(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    apply(ms(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic test_reset();
    exp_t got, want;
    do_reset();
    exp_q.push_back(me(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'd0, 16'd0));
    @(negedge clk);
    got  = sample();
    want = exp_q.pop_front();
    n_run++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL reset: got %b want %b", got, want);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_fwd_exmem();
    stim_t s[4];
    exp_t  e[4];
    exp_t  got, want;
    do_reset();
    s[0] = ms(0, 1, 1, 2, 5, 1, 0, 0, 0, 0); e[0] = me(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    s[1] = ms(0, 1, 5, 1, 6, 1, 0, 0, 0, 0); e[1] = me(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    s[2] = ms(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); e[2] = me(0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0);
    s[3] = ms(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); e[3] = me(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    for (int i = 0; i < 4; i++) begin
      apply(s[i]);
      exp_q.push_back(e[i]);
      @(negedge clk);
      got  = sample();
      want = exp_q.pop_front();
      n_run++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL fwd_exmem[%0d]: got %b want %b", i, got, want);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_fwd_memwb();
    stim_t s[8];
    exp_t  e[8];
    exp_t  got, want;
    do_reset();
    s[0] = ms(0, 1, 1, 2, 5, 1, 0, 0, 0, 0); e[0] = me(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    s[1] = ms(0, 1, 3, 4, 9, 1, 0, 0, 0, 0); e[1] = me(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    s[2] = ms(0, 1, 5, 1, 6, 1, 0, 0, 0, 0); e[2] = me(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    s[3] = ms(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); e[3] = me(0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0);
    // Both MEM and WB write x5: EX/MEM must win.
    s[4] = ms(0, 1, 1, 2, 5, 1, 0, 0, 0, 0); e[4] = me(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    s[5] = ms(0, 1, 3, 4, 5, 1, 0, 0, 0, 0); e[5] = me(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    s[6] = ms(0, 1, 5, 5, 7, 1, 0, 0, 0, 0); e[6] = me(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    s[7] = ms(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); e[7] = me(0, 0, 0, 0, 0, 2'b01, 2'b01, 0, 0);
    for (int i = 0; i < 8; i++) begin
      apply(s[i]);
      exp_q.push_back(e[i]);
      @(negedge clk);
      got  = sample();
      want = exp_q.pop_front();
      n_run++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL fwd_memwb[%0d]: got %b want %b", i, got, want);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_load_use();
    stim_t s[5];
    exp_t  e[5];
    exp_t  got, want;
    do_reset();
    s[0] = ms(0, 1, 2, 0, 7, 1, 1, 0, 0, 0); e[0] = me(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    s[1] = ms(0, 1, 7, 7, 8, 1, 0, 0, 0, 0); e[1] = me(1, 1, 0, 0, 1, 2'b00, 2'b00, 0, 0);
    s[2] = ms(0, 1, 7, 7, 8, 1, 0, 0, 0, 0); e[2] = me(0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1);
    s[3] = ms(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); e[3] = me(0, 0, 0, 0, 0, 2'b10, 2'b10, 0, 1);
    s[4] = ms(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); e[4] = me(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1);
    for (int i = 0; i < 5; i++) begin
      apply(s[i]);
      exp_q.push_back(e[i]);
      @(negedge clk);
      got  = sample();
      want = exp_q.pop_front();
      n_run++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL load_use[%0d]: got %b want %b", i, got, want);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_x0();
    stim_t s[4];
    exp_t  e[4];
    exp_t  got, want;
    do_reset();
    s[0] = ms(0, 1, 1, 2, 0, 1, 1, 0, 0, 0); e[0] = me(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    s[1] = ms(0, 1, 0, 0, 3, 1, 0, 0, 0, 0); e[1] = me(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    s[2] = ms(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); e[2] = me(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    s[3] = ms(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); e[3] = me(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    for (int i = 0; i < 4; i++) begin
      apply(s[i]);
      exp_q.push_back(e[i]);
      @(negedge clk);
      got  = sample();
      want = exp_q.pop_front();
      n_run++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL x0[%0d]: got %b want %b", i, got, want);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_branch();
    stim_t s[6];
    exp_t  e[6];
    exp_t  got, want;
    do_reset();
    // Row 1: branch coincides with a load-use; the load-use is dropped.
    s[0] = ms(0, 1, 2, 0, 7, 1, 1, 0, 0, 0); e[0] = me(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    s[1] = ms(0, 1, 7, 7, 8, 1, 0, 1, 0, 0); e[1] = me(0, 0, 0, 1, 1, 2'b00, 2'b00, 0, 0);
    s[2] = ms(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); e[2] = me(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    s[3] = ms(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); e[3] = me(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    s[4] = ms(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); e[4] = me(0, 0, 0, 1, 1, 2'b00, 2'b00, 0, 0);
    s[5] = ms(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); e[5] = me(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    for (int i = 0; i < 6; i++) begin
      apply(s[i]);
      exp_q.push_back(e[i]);
      @(negedge clk);
      got  = sample();
      want = exp_q.pop_front();
      n_run++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL branch[%0d]: got %b want %b", i, got, want);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_mc();
    stim_t s[7];
    exp_t  e[7];
    exp_t  got, want;
    do_reset();
    // Writer x5 sits in MEM across the stall; forwarding must hold steady.
    s[0] = ms(0, 1, 1, 2, 5, 1, 0, 0, 0, 0); e[0] = me(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    s[1] = ms(0, 1, 5, 2, 6, 1, 0, 0, 1, 0); e[1] = me(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    s[2] = ms(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); e[2] = me(1, 1, 1, 0, 0, 2'b01, 2'b00, 2, 0);
    s[3] = ms(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); e[3] = me(1, 1, 1, 0, 0, 2'b01, 2'b00, 2, 1);
    s[4] = ms(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); e[4] = me(1, 1, 1, 0, 0, 2'b01, 2'b00, 2, 2);
    s[5] = ms(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); e[5] = me(0, 0, 0, 0, 0, 2'b01, 2'b00, 2, 3);
    s[6] = ms(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); e[6] = me(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3);
    for (int i = 0; i < 7; i++) begin
      apply(s[i]);
      exp_q.push_back(e[i]);
      @(negedge clk);
      got  = sample();
      want = exp_q.pop_front();
      n_run++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL mc_wait[%0d]: got %b want %b", i, got, want);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_mid_mc();
    stim_t s[5];
    exp_t  e[5];
    exp_t  got, want;
    do_reset();
    s[0] = ms(0, 1, 1, 2, 5, 1, 0, 0, 1, 0); e[0] = me(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    s[1] = ms(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); e[1] = me(1, 1, 1, 0, 0, 2'b00, 2'b00, 2, 0);
    s[2] = ms(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); e[2] = me(1, 1, 1, 0, 0, 2'b00, 2'b00, 2, 1);
    s[3] = ms(0, 1, 5, 0, 6, 1, 0, 0, 0, 0); e[3] = me(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    s[4] = ms(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); e[4] = me(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    for (int i = 0; i < 5; i++) begin
      apply(s[i]);
      exp_q.push_back(e[i]);
      @(negedge clk);
      got  = sample();
      want = exp_q.pop_front();
      n_run++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL reset_mid_mc[%0d]: got %b want %b", i, got, want);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    stim_t s[9];
    exp_t  e[9];
    exp_t  got, want;
    do_reset();
    // Branch beats mc_start; mc_start beats load-use; done on first wait cycle.
    s[0] = ms(0, 0, 0, 0, 0, 0, 0, 1, 1, 0); e[0] = me(0, 0, 0, 1, 1, 2'b00, 2'b00, 0, 0);
    s[1] = ms(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); e[1] = me(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    s[2] = ms(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); e[2] = me(0, 0, 0, 0, 0, 2'b00, 2'b00, 2, 0);
    s[3] = ms(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); e[3] = me(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    s[4] = ms(0, 1, 2, 0, 7, 1, 1, 0, 0, 0); e[4] = me(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    s[5] = ms(0, 1, 7, 7, 8, 1, 0, 0, 1, 0); e[5] = me(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    s[6] = ms(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); e[6] = me(1, 1, 1, 0, 0, 2'b01, 2'b01, 2, 0);
    s[7] = ms(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); e[7] = me(0, 0, 0, 0, 0, 2'b01, 2'b01, 2, 1);
    s[8] = ms(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); e[8] = me(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1);
    for (int i = 0; i < 9; i++) begin
      apply(s[i]);
      exp_q.push_back(e[i]);
      @(negedge clk);
      got  = sample();
      want = exp_q.pop_front();
      n_run++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got %b want %b", i, got, want);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    apply(ms(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    test_reset();
    test_fwd_exmem();
    test_fwd_memwb();
    test_load_use();
    test_x0();
    test_branch();
    test_mc();
    test_reset_mid_mc();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
